// File: rtl/rend_sync_pkg.sv
// Shared types and defaults for the pulse rate bridge.
package rend_sync_pkg;

    typedef enum logic {
        PRB_COUNT,
        PRB_MERGE
    } prb_mode_e;

    localparam int unsigned PRB_DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/pulse_rate_bridge_if.sv
// Event-pulse bus between fast producers and the pulse rate bridge.
interface pulse_rate_bridge_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 4
);

    logic                          slow_en;
    logic [CHANNELS-1:0]           pulse_in;
    logic [CHANNELS-1:0]           pulse_out;
    logic [CHANNELS*CNT_WIDTH-1:0] pending;
    logic [CHANNELS-1:0]           overflow;

    modport master (
        output slow_en,
        output pulse_in,
        input  pulse_out,
        input  pending,
        input  overflow
    );

    modport slave (
        input  slow_en,
        input  pulse_in,
        output pulse_out,
        output pending,
        output overflow
    );

endinterface

// File: rtl/pulse_rate_chan.sv
// One bridge channel: pending-event counter, held output level and sticky overflow flag.
module pulse_rate_chan
    import rend_sync_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PRB_DEFAULT_CNT_WIDTH,
    parameter prb_mode_e   MODE      = PRB_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 slow_en,
    input  logic                 pulse_in,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 pulse_out,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 dec;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        ovf_d = ovf_q;
        dec   = slow_en && (cnt_q != '0);

        // Output samples the queue before this cycle's update, so a coincident pulse waits.
        if (slow_en) begin
            out_d = (cnt_q != '0);
        end

        if (MODE == PRB_MERGE) begin
            if (pulse_in) begin
                cnt_d = CntOne;
            end else if (dec) begin
                cnt_d = '0;
            end
        end else begin
            if (pulse_in && !dec) begin
                if (cnt_q == '1) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end else if (!pulse_in && dec) begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt       = cnt_q;
    assign pulse_out = out_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/pulse_rate_bridge.sv
// Multi-channel fast-pulse to slow-strobe bridge: one independent channel per event source.
module pulse_rate_bridge
    import rend_sync_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = PRB_DEFAULT_CNT_WIDTH,
    parameter prb_mode_e   MODE      = PRB_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    pulse_rate_bridge_if.slave  bus
);

    logic [CNT_WIDTH-1:0] cnt_arr [CHANNELS];
    logic [CHANNELS-1:0]  out_vec;
    logic [CHANNELS-1:0]  ovf_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pulse_rate_chan #(
            .CNT_WIDTH (CNT_WIDTH),
            .MODE      (MODE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .slow_en   (bus.slow_en),
            .pulse_in  (bus.pulse_in[i]),
            .cnt       (cnt_arr[i]),
            .pulse_out (out_vec[i]),
            .overflow  (ovf_vec[i])
        );

        assign bus.pending[i*CNT_WIDTH +: CNT_WIDTH] = cnt_arr[i];
    end

    assign bus.pulse_out = out_vec;
    assign bus.overflow  = ovf_vec;

endmodule
